uart_port_arbiter: RTL and testbench

UART_PORT_ARBITER -- requirements
Module: uart_port_arbiter

---
 rtl/uart_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_uart_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_port_arbiter.sv
// uart_port_arbiter
// Shares one host UART port between four device UART ports. A device claims
// the host by pulling its line low (start bit) while the arbiter is idle;
// round-robin picks among simultaneous claimants. The grant is dropped after
// IDLE_CYCLES quiet clocks on both directions. A manual override pins the
// route to man_sel for as long as man_en is held.
// IDLE_CYCLES must fit in CNT_W bits (2**CNT_W > IDLE_CYCLES).

module uart_port_arbiter #(
  parameter int IDLE_CYCLES = 1024,
  parameter int CNT_W       = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_host,
  input  logic [3:0] rx_dev,
  input  logic       man_en,
  input  logic [1:0] man_sel,
  output logic       tx_host,
  output logic [3:0] tx_dev,
  output logic [1:0] sel,
  output logic       grant_valid,
  output logic [2:0] led
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    MANUAL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Round-robin pick: scan base+1, base+2, base+3, base (mod 4) and return
  // {found, index} of the first line that is low.
  function automatic logic [2:0] rr_pick(input logic [1:0] base,
                                         input logic [3:0] lines);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      cand = base + 2'(k);
      if (!res[2] && !lines[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic       sync_host_r;
  logic [3:0] sync_dev_r;
  logic       s_host;
  logic [3:0] s_dev;

  state_t           state_r;
  logic [1:0]       last_sel_r;
  logic [CNT_W-1:0] cnt_r;

  state_t           nxt_state_s;
  logic [1:0]       nxt_sel_s;
  logic [1:0]       nxt_last_sel_s;
  logic [CNT_W-1:0] nxt_cnt_s;
  logic             nxt_gv_s;
  logic             nxt_tx_host_s;
  logic [3:0]       nxt_tx_dev_s;
  logic             route_en_s;
  logic [1:0]       route_idx_s;
  logic [2:0]       pick_s;

  // Two-flop synchronizers for all incoming serial lines; idle level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_host_r <= 1'b1;
      s_host      <= 1'b1;
      sync_dev_r  <= 4'hF;
      s_dev       <= 4'hF;
    end else begin
      sync_host_r <= rx_host;
      s_host      <= sync_host_r;
      sync_dev_r  <= rx_dev;
      s_dev       <= sync_dev_r;
    end
  end

  // Next-state, grant bookkeeping and routing for the following clock.
  always_comb begin
    nxt_state_s    = state_r;
    nxt_sel_s      = sel;
    nxt_last_sel_s = last_sel_r;
    nxt_cnt_s      = cnt_r;
    nxt_gv_s       = 1'b0;
    route_en_s     = 1'b0;
    route_idx_s    = sel;
    pick_s         = rr_pick(last_sel_r, s_dev);

    case (state_r)
      IDLE: begin
        if (man_en) begin
          nxt_state_s = MANUAL;
          nxt_sel_s   = man_sel;
          nxt_gv_s    = 1'b1;
          route_en_s  = 1'b1;
          route_idx_s = man_sel;
        end else if (pick_s[2]) begin
          // Route already on the grant edge so data keeps a fixed latency.
          nxt_state_s = GRANT;
          nxt_sel_s   = pick_s[1:0];
          nxt_gv_s    = 1'b1;
          nxt_cnt_s   = '0;
          route_en_s  = 1'b1;
          route_idx_s = pick_s[1:0];
        end else begin
          nxt_state_s = IDLE;
        end
      end

      GRANT: begin
        if (man_en) begin
          nxt_state_s = MANUAL;
          nxt_sel_s   = man_sel;
          nxt_gv_s    = 1'b1;
          nxt_cnt_s   = '0;
          route_en_s  = 1'b1;
          route_idx_s = man_sel;
        end else if (cnt_r == CNT_MAX) begin
          nxt_state_s    = IDLE;
          nxt_last_sel_s = sel;
          nxt_cnt_s      = '0;
        end else begin
          nxt_gv_s    = 1'b1;
          route_en_s  = 1'b1;
          route_idx_s = sel;
          // Any low level in either direction means the link is still busy.
          if (!s_dev[sel] || !s_host) begin
            nxt_cnt_s = '0;
          end else begin
            nxt_cnt_s = cnt_r + CNT_ONE;
          end
        end
      end

      MANUAL: begin
        nxt_cnt_s = '0;
        if (man_en) begin
          nxt_sel_s   = man_sel;
          nxt_gv_s    = 1'b1;
          route_en_s  = 1'b1;
          route_idx_s = man_sel;
        end else begin
          nxt_state_s    = IDLE;
          nxt_last_sel_s = sel;
        end
      end

      default: begin
        nxt_state_s = IDLE;
        nxt_cnt_s   = '0;
      end
    endcase

    nxt_tx_dev_s = 4'hF;
    if (route_en_s) begin
      nxt_tx_host_s             = s_dev[route_idx_s];
      nxt_tx_dev_s[route_idx_s] = s_host;
    end else begin
      nxt_tx_host_s = 1'b1;
    end
  end

  // State, bookkeeping and every output are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      sel         <= 2'd0;
      last_sel_r  <= 2'd3;
      cnt_r       <= '0;
      grant_valid <= 1'b0;
      tx_host     <= 1'b1;
      tx_dev      <= 4'hF;
      led         <= 3'b000;
    end else begin
      state_r     <= nxt_state_s;
      sel         <= nxt_sel_s;
      last_sel_r  <= nxt_last_sel_s;
      cnt_r       <= nxt_cnt_s;
      grant_valid <= nxt_gv_s;
      tx_host     <= nxt_tx_host_s;
      tx_dev      <= nxt_tx_dev_s;
      led         <= {nxt_gv_s, nxt_sel_s};
    end
  end

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Directed bench for uart_port_arbiter, built with IDLE_CYCLES=8 so that
// timeouts are short. Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point.

module tb_uart_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_host;
  logic [3:0] rx_dev;
  logic       man_en;
  logic [1:0] man_sel;
  logic       tx_host;
  logic [3:0] tx_dev;
  logic [1:0] sel;
  logic       grant_valid;
  logic [2:0] led;

  int errors = 0;
  int checks = 0;

  uart_port_arbiter #(.IDLE_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .rx_host(rx_host), .rx_dev(rx_dev),
    .man_en(man_en), .man_sel(man_sel), .tx_host(tx_host), .tx_dev(tx_dev),
    .sel(sel), .grant_valid(grant_valid), .led(led)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_gv(input logic val, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      if (grant_valid === val) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_host = 1'b1; rx_dev = 4'hF; man_en = 1'b0; man_sel = 2'd0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_host = 1'b1; rx_dev = 4'hF; man_en = 1'b0; man_sel = 2'd0;
    tick(2);
    checks++; if ({tx_host, tx_dev, grant_valid, sel, led} !== 11'b1_1111_0_00_000) begin
      errors++; $display("FAIL reset_outputs: got tx_host=%b tx_dev=%h gv=%b sel=%0d led=%b, want 1 f 0 0 000",
                         tx_host, tx_dev, grant_valid, sel, led);
    end
    rst = 1'b0;
    tick(4);
    checks++; if (grant_valid !== 1'b0) begin
      errors++; $display("FAIL reset_quiet: got gv=%b want 0", grant_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    rx_dev = 4'b1011;
    tick(2);
    checks++; if (grant_valid !== 1'b0) begin
      errors++; $display("FAIL single_early: got gv=%b want 0 after 2 clocks", grant_valid);
    end
    tick(1);
    checks++; if ({grant_valid, sel, led, tx_host, tx_dev} !== 11'b1_10_110_0_1111) begin
      errors++; $display("FAIL single_grant: got gv=%b sel=%0d led=%b tx_host=%b tx_dev=%h, want 1 2 110 0 f",
                         grant_valid, sel, led, tx_host, tx_dev);
    end
    rx_dev = 4'hF;
    tick(2);
    checks++; if (tx_host !== 1'b0) begin
      errors++; $display("FAIL single_tx_lat: got tx_host=%b want 0", tx_host);
    end
    tick(1);
    checks++; if (tx_host !== 1'b1) begin
      errors++; $display("FAIL single_tx_follow: got tx_host=%b want 1", tx_host);
    end
    rx_host = 1'b0;
    tick(3);
    checks++; if (tx_dev !== 4'b1011) begin
      errors++; $display("FAIL single_host_route: got tx_dev=%b want 1011", tx_dev);
    end
    rx_host = 1'b1;
  endtask

  task automatic test_timeout();
    do_reset();
    rx_dev = 4'b1101;
    tick(3);
    checks++; if ({grant_valid, sel} !== 3'b1_01) begin
      errors++; $display("FAIL timeout_grant: got gv=%b sel=%0d want 1 1", grant_valid, sel);
    end
    rx_dev = 4'hF;
    tick(10);
    checks++; if (grant_valid !== 1'b1) begin
      errors++; $display("FAIL timeout_hold: got gv=%b want 1", grant_valid);
    end
    tick(1);
    checks++; if ({grant_valid, sel, led} !== 6'b0_01_001) begin
      errors++; $display("FAIL timeout_release: got gv=%b sel=%0d led=%b want 0 1 001", grant_valid, sel, led);
    end
    // Second grant: a one-clock low pulse seen at count 7 restarts the count.
    do_reset();
    rx_dev = 4'b1101;
    tick(3);
    rx_dev = 4'hF;
    tick(7);
    rx_dev = 4'b1101;
    tick(1);
    rx_dev = 4'hF;
    tick(3);
    checks++; if (grant_valid !== 1'b1) begin
      errors++; $display("FAIL timeout_restart_a: got gv=%b want 1", grant_valid);
    end
    tick(7);
    checks++; if (grant_valid !== 1'b1) begin
      errors++; $display("FAIL timeout_restart_b: got gv=%b want 1", grant_valid);
    end
    tick(1);
    checks++; if (grant_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_restart_rel: got gv=%b want 0", grant_valid);
    end
  endtask

  task automatic test_round_robin();
    logic       ok;
    logic [1:0] prev;
    logic [1:0] exp_sel;
    do_reset();
    rx_dev = 4'h0;
    wait_gv(1'b1, 6, ok);
    checks++; if (ok !== 1'b1) begin
      errors++; $display("FAIL rr_first_wait: got no grant, want grant within 6 clocks");
    end
    checks++; if (sel !== 2'd0) begin
      errors++; $display("FAIL rr_first_sel: got sel=%0d want 0", sel);
    end
    prev = 2'd0;
    for (int n = 1; n <= 4; n++) begin
      exp_sel = 2'(n);
      rx_dev = 4'h0;
      rx_dev[prev] = 1'b1;
      tick(10);
      checks++; if (grant_valid !== 1'b1) begin
        errors++; $display("FAIL rr_hold_%0d: got gv=%b want 1", n, grant_valid);
      end
      tick(1);
      checks++; if (grant_valid !== 1'b0) begin
        errors++; $display("FAIL rr_release_%0d: got gv=%b want 0", n, grant_valid);
      end
      rx_dev = 4'h0;
      wait_gv(1'b1, 4, ok);
      checks++; if ({ok, sel} !== {1'b1, exp_sel}) begin
        errors++; $display("FAIL rr_order_%0d: got ok=%b sel=%0d want 1 %0d", n, ok, sel, exp_sel);
      end
      prev = exp_sel;
    end
    rx_dev = 4'hF;
  endtask

  task automatic test_manual();
    logic ok;
    do_reset();
    rx_dev = 4'b1110;
    rx_host = 1'b0;
    tick(3);
    checks++; if ({grant_valid, sel, tx_dev} !== 7'b1_00_1110) begin
      errors++; $display("FAIL man_pre_grant: got gv=%b sel=%0d tx_dev=%b want 1 0 1110", grant_valid, sel, tx_dev);
    end
    man_en = 1'b1; man_sel = 2'd3;
    tick(1);
    checks++; if ({grant_valid, sel, tx_dev} !== 7'b1_11_0111) begin
      errors++; $display("FAIL man_takeover: got gv=%b sel=%0d tx_dev=%b want 1 3 0111", grant_valid, sel, tx_dev);
    end
    rx_host = 1'b1; rx_dev = 4'hF;
    tick(20);
    checks++; if ({grant_valid, sel, tx_dev} !== 7'b1_11_1111) begin
      errors++; $display("FAIL man_no_timeout: got gv=%b sel=%0d tx_dev=%b want 1 3 1111", grant_valid, sel, tx_dev);
    end
    rx_host = 1'b0;
    tick(3);
    man_sel = 2'd1;
    tick(1);
    checks++; if ({sel, tx_dev} !== 6'b01_1101) begin
      errors++; $display("FAIL man_reroute: got sel=%0d tx_dev=%b want 1 1101", sel, tx_dev);
    end
    man_en = 1'b0; rx_host = 1'b1;
    tick(1);
    checks++; if ({grant_valid, tx_dev, led} !== 8'b0_1111_001) begin
      errors++; $display("FAIL man_exit: got gv=%b tx_dev=%b led=%b want 0 1111 001", grant_valid, tx_dev, led);
    end
    rx_dev = 4'h0;
    wait_gv(1'b1, 6, ok);
    checks++; if ({ok, sel} !== 3'b1_10) begin
      errors++; $display("FAIL man_last_sel: got ok=%b sel=%0d want 1 2", ok, sel);
    end
    rx_dev = 4'hF;
  endtask

  task automatic test_host_only();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      rx_host = ~rx_host;
      tick(1);
      checks++; if ({grant_valid, tx_dev} !== 5'b0_1111) begin
        errors++; $display("FAIL host_only_%0d: got gv=%b tx_dev=%b want 0 1111", i, grant_valid, tx_dev);
      end
    end
    rx_host = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    rx_dev = 4'b1011;
    rx_host = 1'b0;
    tick(5);
    checks++; if ({grant_valid, tx_dev} !== 5'b1_1011) begin
      errors++; $display("FAIL areset_pre: got gv=%b tx_dev=%b want 1 1011", grant_valid, tx_dev);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++; if ({tx_host, tx_dev, grant_valid, sel, led} !== 11'b1_1111_0_00_000) begin
      errors++; $display("FAIL areset_now: got tx_host=%b tx_dev=%b gv=%b sel=%0d led=%b want 1 1111 0 0 000",
                         tx_host, tx_dev, grant_valid, sel, led);
    end
    tick(1);
    rst = 1'b0; rx_dev = 4'hF; rx_host = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx_host = 1'b1; rx_dev = 4'hF; man_en = 1'b0; man_sel = 2'd0;
    test_reset();
    test_single();
    test_timeout();
    test_round_robin();
    test_manual();
    test_host_only();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
